serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle A − B − bin engine. It is the subtract-direction counterpart of the team's 4-bit ripple-carry adder datapath.
- Operands are loaded on a start handshake. One bit is processed per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- The block gives area-cheap subtraction to sequential datapaths: ALU, counters, comparators.

Parameters:
WIDTH, 4, operand/result width in bits (≥2)
CW, 3, bit-counter width; must satisfy 2^CW ≥ WIDTH

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only when ready=1
A  input  WIDTH  minuend, sampled on the accept cycle
B  input  WIDTH  subtrahend, sampled on the accept cycle
bin  input  1  borrow-in, sampled on the accept cycle
ready  output  1  high in IDLE and DONE (can accept start)
busy  output  1  high in SHIFT
done  output  1  one-cycle pulse when result valid
d  output  WIDTH  difference A − B − bin mod 2^WIDTH
bout  output  1  borrow-out (1 ⇔ A < B + bin, unsigned)

Behaviour:
- Reset (synchronous, rst high at rising edge): state=IDLE, d=0, bout=0, done=0, busy=0, ready=1. Internal shift registers, borrow FF and counter are cleared. rst has priority over every other input.
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT on start=1:
  - Load a_sh←A, b_sh←B, brw←bin, cnt←0.
  - Clear the internal result shift register.
- SHIFT, each cycle:
  - diff = a_sh[0] ^ b_sh[0] ^ brw.
  - brw ← (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw).
  - Shift diff into the result MSB, then shift a_sh and b_sh right by 1. cnt ← cnt+1.
  - When cnt == WIDTH−1, go to DONE and, in that same edge, update d ← final result and bout ← final borrow.
- SHIFT lasts exactly WIDTH cycles.
- DONE (1 cycle): done=1, ready=1.
  - start=1 → behave as IDLE accept: load operands and go to SHIFT.
  - Otherwise go to IDLE.
- Latency: start accepted at edge k → done=1 during the cycle after edge k+WIDTH. d/bout are valid from that cycle.
- d/bout hold their value until the end of the next operation, including through IDLE. They do not change during SHIFT.
- start while busy=1: ignored. No queuing, no error flag. A/B/bin may change freely after the accept edge.
- Throughput: back-to-back operations every WIDTH+1 cycles (start held high or re-asserted in DONE).
- Reset mid-SHIFT: operation is aborted, all outputs return to reset values, and no done pulse is issued.
- Arithmetic is unsigned mod 2^WIDTH. Signed users derive overflow externally.

Decomposition:
- Shared package/header holds:
  - State encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2 (2'd3 unreachable → IDLE).
  - Default WIDTH.
- One sub-module, full_subtractor (a, b, bin → diff, bout), purely combinational. It is instantiated once and mirrors the adder's full-adder cell.

Test Plan:
- WIDTH=4: rst 2 cycles → d=0, bout=0, ready=1, done=0. Then A=9, B=3, bin=0, start 1 cycle → busy for 4 cycles, done pulse 5 cycles after the accept edge, d=6, bout=0.
- A=3, B=9, bin=0 → d=4'hA, bout=1. Then A=0, B=0, bin=1 → d=4'hF, bout=1. Then A=5, B=5, bin=0 → d=0, bout=0.
- During SHIFT of A=9, B=3: pulse start with A=1, B=1 → ignored, result still d=6. Then hold start high with A=7, B=2 → the second op is accepted in the DONE cycle, and its done appears exactly 5 cycles after the first done, with d=5.
- Assert rst in the 2nd SHIFT cycle of A=12, B=4 → next cycle state=IDLE, d=0, bout=0, no done pulse. A fresh op A=12, B=4 then gives d=8.
- WIDTH=8 instance: A=8'h80, B=8'h01, bin=0 → d=8'h7F, bout=0 after 9 cycles. A=8'h00, B=8'hFF, bin=1 → d=8'h00, bout=1.
- Random sweep, both widths: compare d/bout against {bout,d} = {1'b0,A} − B − bin for 1000 ops with random start gaps, and check the done-pulse spacing.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : FSM encoding (IDLE/SHIFT/DONE; 2'd3 is unused and recovers to IDLE)
//   DEFAULT_WIDTH : default operand/result width
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: diff = a - b - bin, with borrow out.
// This is the subtract-direction twin of the adder's full-adder cell.
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   diff      : difference bit
//   bout      : borrow out (1 when a < b + bin)
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bin engine. Operands load on an accepted start; one bit
// is resolved per clock, LSB first, through a single full_subtractor cell and
// a borrow flip-flop. The result and borrow-out are published on the last
// SHIFT edge and held until the next operation completes.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, accepted only while ready=1
//   A, B, bin  : minuend, subtrahend, borrow-in (sampled on accept)
//   ready      : high in IDLE and DONE
//   busy       : high in SHIFT
//   done       : one-cycle pulse when d/bout are fresh
//   d, bout    : difference mod 2^WIDTH and unsigned borrow-out
//
// state | meaning
// IDLE  | waiting for start; last result held
// SHIFT | one bit per cycle, WIDTH cycles total
// DONE  | result valid for one cycle; start here is accepted immediately
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_brw;
    logic             r_bout;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic             w_diff;
    logic             w_brw_nxt;

    full_subtractor u_fs (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_brw),
        .diff (w_diff),
        .bout (w_brw_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_brw   <= 1'b0;
            r_bout  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_a_sh  <= A;
                        r_b_sh  <= B;
                        r_brw   <= bin;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        r_state <= ST_SHIFT;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // Difference bits enter at the MSB so that after WIDTH
                    // shifts the LSB-first stream lines up as the result.
                    r_res  <= {w_diff, r_res[WIDTH-1:1]};
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_brw  <= w_brw_nxt;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == LAST_BIT) begin
                        // Publish straight from the cell outputs so d/bout
                        // are valid in the same cycle done is raised.
                        r_d     <= {w_diff, r_res[WIDTH-1:1]};
                        r_bout  <= w_brw_nxt;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;
    assign d     = r_d;
    assign bout  = r_bout;

endmodule
